// File: rtl/note_lane_scheduler.sv
// note_lane_scheduler
// Sequences falling notes for a 3-lane (R/G/B) rhythm display. It steps a small
// beat pattern and allocates notes into a shared pool of slots. It advances the
// slot Y positions, retires notes that reach the bottom line, and scores lane
// button hits against the hit window.
// Build option: define NOTE_SCHED_LOOP_EN to make the pattern loop for as long as
// start stays high. Dropping start while running then moves the game to DRAIN.
// Without the macro the pattern plays once and start is ignored while running.
module note_lane_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int PAT_LEN   = 8,
    parameter int POS_W     = 10,
    parameter int BOTTOM_Y  = 479,
    parameter int HIT_Y     = 440,
    parameter int HIT_WIN   = 20
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       beat_tick,
    input  logic                       move_tick,
    input  logic [2:0]                 hit_btn,
    input  logic                       pat_wr_en,
    input  logic [$clog2(PAT_LEN)-1:0] pat_wr_addr,
    input  logic [2:0]                 pat_wr_data,
    output logic [NUM_SLOTS-1:0]       slot_valid,
    output logic [2*NUM_SLOTS-1:0]     slot_lane,
    output logic [POS_W*NUM_SLOTS-1:0] slot_pos,
    output logic [1:0]                 state,
    output logic [7:0]                 hits,
    output logic [7:0]                 misses
);

    localparam int IDX_W = $clog2(PAT_LEN);
    // In one cycle, up to NUM_SLOTS notes can retire and up to 3 notes can be dropped.
    localparam int CNT_W = $clog2(NUM_SLOTS + 4);

    localparam logic [POS_W-1:0] BOTTOM   = POS_W'(BOTTOM_Y);
    localparam logic [POS_W-1:0] WIN_LO   = POS_W'(HIT_Y - HIT_WIN);
    localparam logic [POS_W-1:0] WIN_HI   = POS_W'(HIT_Y + HIT_WIN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [PAT_LEN-1:0][2:0]         pat_q, pat_d;
    logic [NUM_SLOTS-1:0]            valid_q, valid_d;
    logic [NUM_SLOTS-1:0][1:0]       lane_q, lane_d;
    logic [NUM_SLOTS-1:0][POS_W-1:0] pos_q, pos_d;
    logic [7:0]                      hits_q, hits_d;
    logic [7:0]                      misses_q, misses_d;

    // Per-cycle scratch for the next-state logic
    logic [NUM_SLOTS-1:0] hit_mask;
    logic [NUM_SLOTS-1:0] free_mask;
    logic [CNT_W-1:0]     hit_cnt;
    logic [CNT_W-1:0]     miss_cnt;
    logic [2:0]           spawn_mask;
    logic                 found;
    logic                 active;

    // Score counters stick at 8'hFF instead of wrapping
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [CNT_W-1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + 9'(b);
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Next-state logic: hits, movement and retirement, spawning, scores and state sequencing
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can leave one unassigned and infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        pat_d      = pat_q;
        valid_d    = valid_q;
        lane_d     = lane_q;
        pos_d      = pos_q;
        hits_d     = hits_q;
        misses_d   = misses_q;
        hit_mask   = '0;
        free_mask  = ~valid_q;
        hit_cnt    = '0;
        miss_cnt   = '0;
        spawn_mask = pat_q[idx_q];
        found      = 1'b0;
        active     = (state_q == S_RUN) || (state_q == S_DRAIN);

        if (active) begin
            // Each lane clears at most one note: the lowest-index valid slot whose
            // pre-move position is inside the hit window.
            for (int l = 0; l < 3; l++) begin
                found = 1'b0;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (!found && hit_btn[l] && valid_q[i] && (lane_q[i] == 2'(l)) &&
                        (pos_q[i] >= WIN_LO) && (pos_q[i] <= WIN_HI)) begin
                        found       = 1'b1;
                        hit_mask[i] = 1'b1;
                        valid_d[i]  = 1'b0;
                        hit_cnt     = hit_cnt + CNT_W'(1);
                    end
                end
            end

            // A hit in this cycle takes priority, so a slot that was just hit neither moves nor retires.
            if (move_tick) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (valid_q[i] && !hit_mask[i]) begin
                        if (pos_q[i] == BOTTOM) begin
                            valid_d[i] = 1'b0;
                            miss_cnt   = miss_cnt + CNT_W'(1);
                        end else begin
                            pos_d[i] = pos_q[i] + POS_W'(1);
                        end
                    end
                end
            end

            hits_d   = sat_add(hits_q, hit_cnt);
            misses_d = sat_add(misses_q, miss_cnt);
        end

        // Spawn only into slots that were already free at the start of the cycle.
        // Lanes are served in the order R, G, B.
        if ((state_q == S_RUN) && beat_tick) begin
            for (int l = 2; l >= 0; l--) begin
                if (spawn_mask[l]) begin
                    found = 1'b0;
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (!found && free_mask[i]) begin
                            found        = 1'b1;
                            free_mask[i] = 1'b0;
                            valid_d[i]   = 1'b1;
                            lane_d[i]    = 2'(l);
                            pos_d[i]     = '0;
                        end
                    end
                    if (!found) begin
                        miss_cnt = miss_cnt + CNT_W'(1);
                    end
                end
            end
            misses_d = sat_add(misses_q, miss_cnt);
            idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (pat_wr_en) begin
                    pat_d[pat_wr_addr] = pat_wr_data;
                end
                if (start) begin
                    state_d  = S_RUN;
                    idx_d    = '0;
                    valid_d  = '0;
                    lane_d   = '0;
                    pos_d    = '0;
                    hits_d   = '0;
                    misses_d = '0;
                end
            end
            S_RUN: begin
`ifdef NOTE_SCHED_LOOP_EN
                if (!start) begin
                    state_d = S_DRAIN;
                end
`else
                if (beat_tick && (idx_q == LAST_IDX)) begin
                    state_d = S_DRAIN;
                end
`endif
            end
            S_DRAIN: begin
                if (valid_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State registers. The pattern store resets together with the rest of the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the pattern store is an 8x3 flop array, not a RAM macro, so it can and must be cleared on reset.
            pat_q    <= '0;
            state_q  <= S_IDLE;
            idx_q    <= '0;
            valid_q  <= '0;
            lane_q   <= '0;
            pos_q    <= '0;
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from the same pre-edge values.
            pat_q    <= pat_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            lane_q   <= lane_d;
            pos_q    <= pos_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign slot_valid = valid_q;
    assign slot_lane  = lane_q;
    assign slot_pos   = pos_q;
    assign state      = state_q;
    assign hits       = hits_q;
    assign misses     = misses_q;

endmodule

// File: tb/tb_note_lane_scheduler.sv
// Testbench for note_lane_scheduler. Each scenario task pushes the expected
// {state, slot_valid, hits, misses} snapshot when it drives stimulus. The task
// pops that snapshot and compares it once the registered outputs have updated.
module tb_note_lane_scheduler;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_DRAIN = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        beat_tick;
    logic        move_tick;
    logic [2:0]  hit_btn;
    logic        pat_wr_en;
    logic [2:0]  pat_wr_addr;
    logic [2:0]  pat_wr_data;
    logic [3:0]  slot_valid;
    logic [7:0]  slot_lane;
    logic [39:0] slot_pos;
    logic [1:0]  state;
    logic [7:0]  hits;
    logic [7:0]  misses;

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] vld;
        logic [7:0] h;
        logic [7:0] m;
    } snap_t;

    snap_t exp_q[$];
    snap_t obs_snap;
    snap_t e;
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    note_lane_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .beat_tick   (beat_tick),
        .move_tick   (move_tick),
        .hit_btn     (hit_btn),
        .pat_wr_en   (pat_wr_en),
        .pat_wr_addr (pat_wr_addr),
        .pat_wr_data (pat_wr_data),
        .slot_valid  (slot_valid),
        .slot_lane   (slot_lane),
        .slot_pos    (slot_pos),
        .state       (state),
        .hits        (hits),
        .misses      (misses)
    );

    assign obs_snap = {state, slot_valid, hits, misses};

    function automatic string fmt(input snap_t s);
        return $sformatf("state=%b valid=%b hits=%0d misses=%0d", s.st, s.vld, s.h, s.m);
    endfunction

    task automatic push_exp(input logic [1:0] st, input logic [3:0] vld,
                            input logic [7:0] h, input logic [7:0] m);
        snap_t s;
        s.st  = st;
        s.vld = vld;
        s.h   = h;
        s.m   = m;
        exp_q.push_back(s);
    endtask

    // One clock edge. Outputs are sampled 1 time unit after the edge, and the
    // single-cycle pulse inputs are cleared at that point.
    task automatic step();
        @(posedge clk);
        #1;
        beat_tick = 1'b0;
        move_tick = 1'b0;
        hit_btn   = 3'b000;
        pat_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        start       = 1'b0;
        beat_tick   = 1'b0;
        move_tick   = 1'b0;
        hit_btn     = 3'b000;
        pat_wr_en   = 1'b0;
        pat_wr_addr = 3'd0;
        pat_wr_data = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic write_pat(input logic [2:0] a, input logic [2:0] d);
        pat_wr_en   = 1'b1;
        pat_wr_addr = a;
        pat_wr_data = d;
        step();
    endtask

    task automatic start_game();
        start = 1'b1;
        step();
    endtask

    task automatic beat();
        beat_tick = 1'b1;
        step();
    endtask

    task automatic moves(input int n);
        repeat (n) begin
            move_tick = 1'b1;
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        push_exp(ST_IDLE, 4'b0000, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL reset_idle: got %s want %s", fmt(obs_snap), fmt(e));
        end
        checks++;
        if (slot_pos !== 40'd0 || slot_lane !== 8'd0) begin
            errors++;
            $display("FAIL reset_slots: got lane=%h pos=%h want 0", slot_lane, slot_pos);
        end

        write_pat(3'd0, 3'b100);
        start_game();
        beat();
        push_exp(ST_RUN, 4'b0001, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL reset_pre_run: got %s want %s", fmt(obs_snap), fmt(e));
        end

        // Reset asserted in the middle of the run, away from any clock edge.
        #2;
        reset_n = 1'b0;
        start   = 1'b0;
        @(posedge clk);
        #1;
        push_exp(ST_IDLE, 4'b0000, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL reset_mid_run: got %s want %s", fmt(obs_snap), fmt(e));
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // The pattern store was cleared as well, so the beat spawns nothing.
        start_game();
        beat();
        push_exp(ST_RUN, 4'b0000, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL reset_pat_cleared: got %s want %s", fmt(obs_snap), fmt(e));
        end
    endtask

    task automatic test_spawn();
        do_reset();
        write_pat(3'd0, 3'b101);
        write_pat(3'd1, 3'b010);
        start_game();
        push_exp(ST_RUN, 4'b0000, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL spawn_start: got %s want %s", fmt(obs_snap), fmt(e));
        end

        beat();
        push_exp(ST_RUN, 4'b0011, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL spawn_beat: got %s want %s", fmt(obs_snap), fmt(e));
        end
        checks++;
        if (slot_lane[3:0] !== 4'b00_10 || slot_pos[19:0] !== 20'd0) begin
            errors++;
            $display("FAIL spawn_slots: got lane=%b pos=%h want lane=0010 pos=0", slot_lane[3:0], slot_pos[19:0]);
        end

        // Beat and move in the same cycle: the old notes move, and the new note stays at 0.
        beat_tick = 1'b1;
        move_tick = 1'b1;
        step();
        push_exp(ST_RUN, 4'b0111, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL spawn_beat_move: got %s want %s", fmt(obs_snap), fmt(e));
        end
        checks++;
        if (slot_pos[9:0] !== 10'd1 || slot_pos[19:10] !== 10'd1 ||
            slot_pos[29:20] !== 10'd0 || slot_lane[5:4] !== 2'd1) begin
            errors++;
            $display("FAIL spawn_move_pos: got pos0=%0d pos1=%0d pos2=%0d lane2=%0d want 1 1 0 1",
                     slot_pos[9:0], slot_pos[19:10], slot_pos[29:20], slot_lane[5:4]);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        write_pat(3'd0, 3'b111);
        write_pat(3'd1, 3'b111);
        start_game();
        beat();
        push_exp(ST_RUN, 4'b0111, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL ovf_beat1: got %s want %s", fmt(obs_snap), fmt(e));
        end
        checks++;
        if (slot_lane[5:0] !== 6'b00_01_10) begin
            errors++;
            $display("FAIL ovf_lanes: got %b want 000110", slot_lane[5:0]);
        end

        beat();
        push_exp(ST_RUN, 4'b1111, 8'd0, 8'd2);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL ovf_beat2: got %s want %s", fmt(obs_snap), fmt(e));
        end
        checks++;
        if (slot_lane[7:6] !== 2'd2) begin
            errors++;
            $display("FAIL ovf_slot3_lane: got %0d want 2", slot_lane[7:6]);
        end
    endtask

    task automatic test_hit_miss();
        do_reset();
        write_pat(3'd0, 3'b100);
        write_pat(3'd1, 3'b100);
        start_game();
        beat();
        moves(440);
        push_exp(ST_RUN, 4'b0001, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e || slot_pos[9:0] !== 10'd440) begin
            errors++;
            $display("FAIL hm_at_440: got %s pos=%0d want %s pos=440", fmt(obs_snap), slot_pos[9:0], fmt(e));
        end

        hit_btn = 3'b100;
        step();
        push_exp(ST_RUN, 4'b0000, 8'd1, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL hm_hit: got %s want %s", fmt(obs_snap), fmt(e));
        end

        hit_btn = 3'b111;
        step();
        push_exp(ST_RUN, 4'b0000, 8'd1, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL hm_no_candidate: got %s want %s", fmt(obs_snap), fmt(e));
        end

        beat();
        moves(479);
        push_exp(ST_RUN, 4'b0001, 8'd1, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e || slot_pos[9:0] !== 10'd479) begin
            errors++;
            $display("FAIL hm_at_bottom: got %s pos=%0d want %s pos=479", fmt(obs_snap), slot_pos[9:0], fmt(e));
        end

        moves(1);
        push_exp(ST_RUN, 4'b0000, 8'd1, 8'd1);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL hm_retire: got %s want %s", fmt(obs_snap), fmt(e));
        end
    endtask

    task automatic test_window();
        do_reset();
        write_pat(3'd0, 3'b100);
        write_pat(3'd1, 3'b100);
        write_pat(3'd2, 3'b010);
        write_pat(3'd3, 3'b001);
        start_game();
        beat();
        moves(10);
        beat();
        moves(420);
        // Slot 0 is at 430 and slot 1 at 420, both red; only the lowest index may be hit.
        hit_btn = 3'b100;
        step();
        push_exp(ST_RUN, 4'b0010, 8'd1, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e || slot_pos[19:10] !== 10'd420) begin
            errors++;
            $display("FAIL win_one_per_lane: got %s pos1=%0d want %s pos1=420", fmt(obs_snap), slot_pos[19:10], fmt(e));
        end

        hit_btn = 3'b100;
        step();
        push_exp(ST_RUN, 4'b0000, 8'd2, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL win_lo_edge_r: got %s want %s", fmt(obs_snap), fmt(e));
        end

        beat();
        moves(419);
        hit_btn = 3'b110;
        step();
        push_exp(ST_RUN, 4'b0001, 8'd2, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL win_below: got %s want %s", fmt(obs_snap), fmt(e));
        end

        moves(1);
        hit_btn = 3'b010;
        step();
        push_exp(ST_RUN, 4'b0000, 8'd3, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL win_lo_edge_g: got %s want %s", fmt(obs_snap), fmt(e));
        end

        beat();
        moves(461);
        hit_btn = 3'b001;
        step();
        push_exp(ST_RUN, 4'b0001, 8'd3, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e || slot_pos[9:0] !== 10'd461) begin
            errors++;
            $display("FAIL win_above: got %s pos=%0d want %s pos=461", fmt(obs_snap), slot_pos[9:0], fmt(e));
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        write_pat(3'd0, 3'b100);
        write_pat(3'd1, 3'b111);
        write_pat(3'd2, 3'b100);
        start_game();
        beat();
        moves(460);
        beat();
        push_exp(ST_RUN, 4'b1111, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e || slot_pos[9:0] !== 10'd460) begin
            errors++;
            $display("FAIL sim_full: got %s pos0=%0d want %s pos0=460", fmt(obs_snap), slot_pos[9:0], fmt(e));
        end

        // In one cycle: the hit at 460 wins over the move, the other slots move, and the
        // spawn cannot reuse the slot freed by the hit, so the new note is dropped.
        hit_btn   = 3'b100;
        move_tick = 1'b1;
        beat_tick = 1'b1;
        step();
        push_exp(ST_RUN, 4'b1110, 8'd1, 8'd1);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL sim_hit_move: got %s want %s", fmt(obs_snap), fmt(e));
        end
        checks++;
        if (slot_pos[19:10] !== 10'd1 || slot_pos[29:20] !== 10'd1 || slot_pos[39:30] !== 10'd1) begin
            errors++;
            $display("FAIL sim_others_moved: got %0d %0d %0d want 1 1 1",
                     slot_pos[19:10], slot_pos[29:20], slot_pos[39:30]);
        end
    endtask

    task automatic test_flow();
        logic [3:0] exp_vld;
        logic [7:0] exp_miss;
        do_reset();
        write_pat(3'd0, 3'b100);
        write_pat(3'd7, 3'b001);
        start_game();
        repeat (7) beat();
        push_exp(ST_RUN, 4'b0001, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL flow_seven_beats: got %s want %s", fmt(obs_snap), fmt(e));
        end

        beat();
`ifdef NOTE_SCHED_LOOP_EN
        push_exp(ST_RUN, 4'b0011, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL flow_eighth_beat: got %s want %s", fmt(obs_snap), fmt(e));
        end
        beat();
        push_exp(ST_RUN, 4'b0111, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e || slot_lane[5:4] !== 2'd2) begin
            errors++;
            $display("FAIL flow_wrap_beat: got %s lane2=%0d want %s lane2=2", fmt(obs_snap), slot_lane[5:4], fmt(e));
        end
        start = 1'b0;
        step();
        push_exp(ST_DRAIN, 4'b0111, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL flow_stop: got %s want %s", fmt(obs_snap), fmt(e));
        end
        start    = 1'b1;
        exp_vld  = 4'b0111;
        exp_miss = 8'd3;
`else
        push_exp(ST_DRAIN, 4'b0011, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL flow_eighth_beat: got %s want %s", fmt(obs_snap), fmt(e));
        end
        beat();
        push_exp(ST_DRAIN, 4'b0011, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL flow_drain_beat_ignored: got %s want %s", fmt(obs_snap), fmt(e));
        end
        exp_vld  = 4'b0011;
        exp_miss = 8'd2;
`endif

        moves(479);
        push_exp(ST_DRAIN, exp_vld, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL flow_drain_hold: got %s want %s", fmt(obs_snap), fmt(e));
        end

        moves(1);
        push_exp(ST_DRAIN, 4'b0000, 8'd0, exp_miss);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL flow_retire_all: got %s want %s", fmt(obs_snap), fmt(e));
        end

        step();
        push_exp(ST_DONE, 4'b0000, 8'd0, exp_miss);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL flow_done: got %s want %s", fmt(obs_snap), fmt(e));
        end

        beat_tick   = 1'b1;
        move_tick   = 1'b1;
        hit_btn     = 3'b111;
        pat_wr_en   = 1'b1;
        pat_wr_addr = 3'd0;
        pat_wr_data = 3'b010;
        step();
        push_exp(ST_DONE, 4'b0000, 8'd0, exp_miss);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL flow_done_ignores: got %s want %s", fmt(obs_snap), fmt(e));
        end

        start = 1'b0;
        step();
        push_exp(ST_IDLE, 4'b0000, 8'd0, exp_miss);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e) begin
            errors++;
            $display("FAIL flow_idle_scores_held: got %s want %s", fmt(obs_snap), fmt(e));
        end

        start_game();
        beat();
        push_exp(ST_RUN, 4'b0001, 8'd0, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_snap !== e || slot_lane[1:0] !== 2'd2) begin
            errors++;
            $display("FAIL flow_restart_pat_kept: got %s lane0=%0d want %s lane0=2", fmt(obs_snap), slot_lane[1:0], fmt(e));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_spawn();
        test_overflow();
        test_hit_miss();
        test_window();
        test_simultaneous();
        test_flow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
